// File: rtl/calc_bcd_convert.sv
// calc_bcd_convert: sequential double-dabble binary-to-BCD converter with start/busy/done handshake
// Optional build macro BCD_LEADING_BLANK_EN replaces leading zero digits with 4'hF.
module calc_bcd_convert #(
  parameter int N      = 9,
  parameter int DIGITS = 3,
  parameter int MAX    = 254
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0]        sr;
  logic [4*DIGITS-1:0] scr, adj, res;
  logic [CW-1:0]       cnt;
  logic                err;
  logic                out_of_range;
  assign out_of_range = value > N'(MAX);
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
  end
`ifdef BCD_LEADING_BLANK_EN
  always_comb begin
    logic lead;
    res  = scr;
    lead = 1'b1;
    for (int d = DIGITS - 1; d > 0; d--) begin
      lead = lead && (scr[4*d+:4] == 4'd0);
      res[4*d+:4] = lead ? 4'hF : scr[4*d+:4];
    end
  end
`else
  assign res = scr;
`endif
  // Out-of-range values skip shifting: a zero count sends SHIFT straight to DONE
  always_comb begin
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == '0 ? DONE : SHIFT) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      scr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      bcd   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        sr  <= value;
        scr <= '0;
        err <= out_of_range;
        cnt <= out_of_range ? '0 : CW'(N);
      end
      if (state == SHIFT && cnt != '0) begin
        {scr, sr} <= {adj[4*DIGITS-2:0], sr, 1'b0};
        cnt       <= cnt - CW'(1);
      end
      if (state == SHIFT && cnt == '0) begin
        bcd <= err ? {DIGITS{4'hE}} : res;
        ovf <= err;
      end
    end
  end
endmodule

// File: tb/tb_calc_bcd_convert.sv
// tb_calc_bcd_convert: directed self-checking bench for calc_bcd_convert
// Expected digits follow BCD_LEADING_BLANK_EN when the bench is built with it.
module tb_calc_bcd_convert;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  value = '0;
  logic        busy, done, ovf;
  logic [11:0] bcd;
  int checks = 0;
  int errors = 0;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [11:0] X0 = 12'hFF0, X7 = 12'hFF7, X18 = 12'hF18, X45 = 12'hF45;
`else
  localparam logic [11:0] X0 = 12'h000, X7 = 12'h007, X18 = 12'h018, X45 = 12'h045;
`endif

  calc_bcd_convert dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge inside the done cycle; lat counts edges after acceptance
  task automatic run(input logic [8:0] v, output int lat);
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    value = v;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    value = ~v;
    check("busy_acc", {31'd0, busy}, 32'd1);
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("busy_done", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int lat, n;
    logic [11:0] seen;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_bcd", {20'd0, bcd}, 32'h000);
    @(negedge clk);
    rst = 1'b0;

    run(9'd254, lat);
    check("lat_254", lat, 10);
    check("bcd_254", {20'd0, bcd}, 32'h254);
    check("ovf_254", {31'd0, ovf}, 32'd0);

    run(9'd0, lat);
    check("lat_0", lat, 10);
    check("bcd_0", {20'd0, bcd}, {20'd0, X0});
    run(9'd7, lat);
    check("lat_7", lat, 10);
    check("bcd_7", {20'd0, bcd}, {20'd0, X7});

    run(9'd255, lat);
    check("lat_255", lat, 1);
    check("bcd_255", {20'd0, bcd}, 32'hEEE);
    check("ovf_255", {31'd0, ovf}, 32'd1);
    run(9'd18, lat);
    check("lat_18", lat, 10);
    check("bcd_18", {20'd0, bcd}, {20'd0, X18});
    check("ovf_18", {31'd0, ovf}, 32'd0);

    run(9'd511, lat);
    check("lat_511", lat, 1);
    check("bcd_511", {20'd0, bcd}, 32'hEEE);
    check("ovf_511", {31'd0, ovf}, 32'd1);

    @(negedge clk);
    start = 1'b1;
    value = 9'd123;
    @(posedge clk);
    @(negedge clk);
    value = 9'd99;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n = 0;
    seen = '0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        n++;
        seen = bcd;
      end
    end
    check("ign_count", n, 1);
    check("ign_bcd", {20'd0, seen}, 32'h123);
    check("ign_hold", {20'd0, bcd}, 32'h123);

    @(negedge clk);
    start = 1'b1;
    value = 9'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_ovf", {31'd0, ovf}, 32'd0);
    check("mid_bcd", {20'd0, bcd}, 32'h000);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n++;
    end
    check("mid_nodone", n, 0);
    check("mid_bcd_hold", {20'd0, bcd}, 32'h000);

    run(9'd45, lat);
    check("lat_45", lat, 10);
    check("bcd_45", {20'd0, bcd}, {20'd0, X45});
    @(negedge clk);
    check("end_done", {31'd0, done}, 32'd0);
    check("end_bcd", {20'd0, bcd}, {20'd0, X45});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
